// File: rtl/irq_pkg.sv
// Shared types and constants for the vectored interrupt controller.
package irq_pkg;

   localparam int unsigned MAX_SRC        = 8;
   localparam int unsigned ID_W           = 3;
   localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0020;
   localparam int unsigned VEC_STRIDE_DEF = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } irq_state_e;

   // Index of the lowest set bit; all-ones index when nothing is set.
   function automatic logic [ID_W-1:0] lowest_idx(input logic [MAX_SRC-1:0] vec);
      logic [ID_W-1:0] idx;
      idx = ID_W'(MAX_SRC - 1);
      for (int i = int'(MAX_SRC) - 1; i >= 0; i--) begin
         if (vec[i]) idx = ID_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one raw request line plus a rising-edge detector.
module irq_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_rise_c
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_rise_c = r_sync & ~r_prev;

endmodule

// File: rtl/irq_controller.sv
// Vectored fixed-priority interrupt controller with ack/EOI handshake.
// Define IRQ_NEST_EN to let a higher-priority source preempt one in service.
module irq_controller
   import irq_pkg::*;
#(
   parameter int unsigned N_SRC      = 4,
   parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
   parameter int unsigned VEC_STRIDE = VEC_STRIDE_DEF
) (
   input  logic             clk,
   input  logic             Rst,
   input  logic [N_SRC-1:0] EX_irq,
   input  logic             I_bit,
   input  logic             INT_ack,
   input  logic             INT_eoi,
   input  logic             mask_we,
   input  logic [N_SRC-1:0] mask_wdata,
   output logic             INT_irq,
   output logic [31:0]      INT_Vector,
   output logic [2:0]       INT_id,
   output logic [N_SRC-1:0] pending,
   output logic [N_SRC-1:0] in_service
);

   irq_state_e       r_state, w_state_nxt;
   logic             r_irq, w_irq_nxt;
   logic [ID_W-1:0]  r_id, w_id_nxt;
   logic [31:0]      r_vec, w_vec_nxt;
   logic [N_SRC-1:0] r_pend, w_pend_nxt;
   logic [N_SRC-1:0] r_isr, w_isr_nxt;
   logic [N_SRC-1:0] r_mask, w_mask_nxt;
   logic [N_SRC-1:0] w_pend_clr;
   logic [N_SRC-1:0] w_rise;
   logic [N_SRC-1:0] w_elig;
   logic [N_SRC-1:0] w_id_oh;
   logic [ID_W-1:0]  w_win;
   logic [31:0]      w_win_vec;

   for (genvar g = 0; g < int'(N_SRC); g++) begin : g_sync
      irq_sync_edge u_sync (
         .clk      (clk),
         .rst_n    (Rst),
         .i_async  (EX_irq[g]),
         .o_rise_c (w_rise[g])
      );
   end

   assign w_elig    = r_pend & ~r_mask;
   assign w_win     = lowest_idx(MAX_SRC'(w_elig));
   assign w_win_vec = VEC_BASE + 32'(w_win) * 32'(VEC_STRIDE);
   assign w_id_oh   = N_SRC'(1) << r_id;

`ifdef IRQ_NEST_EN
   logic [ID_W-1:0]  w_isr_low;
   logic [N_SRC-1:0] w_isr_low_oh;
   logic [N_SRC-1:0] w_isr_after_eoi;

   // EOI retires the highest-priority handler, which is always the innermost one.
   assign w_isr_low       = lowest_idx(MAX_SRC'(r_isr));
   assign w_isr_low_oh    = N_SRC'(1) << w_isr_low;
   assign w_isr_after_eoi = r_isr & ~w_isr_low_oh;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_irq_nxt   = r_irq;
      w_id_nxt    = r_id;
      w_vec_nxt   = r_vec;
      w_isr_nxt   = r_isr;
      w_pend_clr  = '0;

      case (r_state)
         IDLE: begin
            if ((|w_elig) && !I_bit) begin
               w_state_nxt = REQ;
               w_irq_nxt   = 1'b1;
               w_id_nxt    = w_win;
               w_vec_nxt   = w_win_vec;
            end
         end
         REQ: begin
            if (INT_ack) begin
               w_pend_clr  = w_id_oh;
               w_isr_nxt   = r_isr | w_id_oh;
               w_irq_nxt   = 1'b0;
               w_state_nxt = SERVICE;
            end
         end
         SERVICE: begin
`ifdef IRQ_NEST_EN
            if (INT_eoi) begin
               w_isr_nxt = w_isr_after_eoi;
               if (w_isr_after_eoi == '0) w_state_nxt = IDLE;
            end else if ((|w_elig) && !I_bit && (w_win < w_isr_low)) begin
               w_state_nxt = REQ;
               w_irq_nxt   = 1'b1;
               w_id_nxt    = w_win;
               w_vec_nxt   = w_win_vec;
            end
`else
            if (INT_eoi) begin
               w_isr_nxt   = r_isr & ~w_id_oh;
               w_state_nxt = IDLE;
            end
`endif
         end
         default: w_state_nxt = IDLE;
      endcase

      // A fresh edge outranks the ack clear so no request is lost.
      w_pend_nxt = (r_pend & ~w_pend_clr) | w_rise;
      w_mask_nxt = mask_we ? mask_wdata : r_mask;
   end

   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         r_state <= IDLE;
         r_irq   <= 1'b0;
         r_id    <= '0;
         r_vec   <= VEC_BASE;
         r_pend  <= '0;
         r_isr   <= '0;
         r_mask  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_irq   <= w_irq_nxt;
         r_id    <= w_id_nxt;
         r_vec   <= w_vec_nxt;
         r_pend  <= w_pend_nxt;
         r_isr   <= w_isr_nxt;
         r_mask  <= w_mask_nxt;
      end
   end

   assign INT_irq    = r_irq;
   assign INT_Vector = r_vec;
   assign INT_id     = r_id;
   assign pending    = r_pend;
   assign in_service = r_isr;

endmodule

// File: tb/tb_irq_controller.sv
// Directed and randomized bench for irq_controller against a cycle-level reference model.
module tb_irq_controller;

   localparam int unsigned N  = 4;
   localparam logic [31:0] VB = 32'h0000_0020;
   localparam int unsigned VS = 4;
   localparam int          HN = 8192;

   logic          clk = 1'b0;
   logic          Rst = 1'b0;
   logic [N-1:0]  EX_irq = '0;
   logic          I_bit = 1'b0;
   logic          INT_ack = 1'b0;
   logic          INT_eoi = 1'b0;
   logic          mask_we = 1'b0;
   logic [N-1:0]  mask_wdata = '0;
   logic          INT_irq;
   logic [31:0]   INT_Vector;
   logic [2:0]    INT_id;
   logic [N-1:0]  pending;
   logic [N-1:0]  in_service;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   irq_controller #(.N_SRC(N), .VEC_BASE(VB), .VEC_STRIDE(VS)) dut (
      .clk        (clk),
      .Rst        (Rst),
      .EX_irq     (EX_irq),
      .I_bit      (I_bit),
      .INT_ack    (INT_ack),
      .INT_eoi    (INT_eoi),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .INT_irq    (INT_irq),
      .INT_Vector (INT_Vector),
      .INT_id     (INT_id),
      .pending    (pending),
      .in_service (in_service)
   );

   // Reference: raw samples are logged per edge; a 0->1 sample pair becomes pending two edges on.
   logic [N-1:0] raw_at [HN];
   int           cyc;
   logic [N-1:0] m_pend, m_mask, m_isr;
   logic         m_irq;
   logic [2:0]   m_id;
   logic [31:0]  m_vec;

   function automatic logic [N-1:0] sample(input int c);
      if (c < 0) return '0;
      return raw_at[c % HN];
   endfunction

   function automatic int lowest(input logic [N-1:0] v);
      for (int i = 0; i < int'(N); i++) if (v[i]) return i;
      return int'(N);
   endfunction

   always @(posedge clk or negedge Rst) begin : ref_model
      logic [N-1:0] rise, elig, clr, isr_n;
      logic         irq_n;
      logic [2:0]   id_n;
      logic [31:0]  vec_n;
      int           w, lo;
      if (!Rst) begin
         m_pend <= '0; m_mask <= '0; m_isr <= '0;
         m_irq  <= 1'b0; m_id <= '0; m_vec <= VB; cyc <= 0;
      end else begin
         rise  = sample(cyc - 2) & ~sample(cyc - 3);
         elig  = m_pend & ~m_mask;
         w     = lowest(elig);
         lo    = lowest(m_isr);
         clr   = '0;
         isr_n = m_isr;
         irq_n = m_irq;
         id_n  = m_id;
         vec_n = m_vec;
         if (m_irq) begin
            if (INT_ack) begin
               clr[m_id]   = 1'b1;
               isr_n[m_id] = 1'b1;
               irq_n       = 1'b0;
            end
         end else if (m_isr != '0) begin
            if (INT_eoi) isr_n[lo] = 1'b0;
`ifdef IRQ_NEST_EN
            else if (elig != '0 && !I_bit && w < lo) begin
               irq_n = 1'b1;
               id_n  = 3'(w);
               vec_n = VB + 32'(w) * 32'(VS);
            end
`endif
         end else if (elig != '0 && !I_bit) begin
            irq_n = 1'b1;
            id_n  = 3'(w);
            vec_n = VB + 32'(w) * 32'(VS);
         end
         m_pend <= (m_pend & ~clr) | rise;
         m_mask <= mask_we ? mask_wdata : m_mask;
         m_isr  <= isr_n;
         m_irq  <= irq_n;
         m_id   <= id_n;
         m_vec  <= vec_n;
         raw_at[cyc % HN] <= EX_irq;
         cyc <= cyc + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("model_irq",  32'(INT_irq),    32'(m_irq));
      chk("model_id",   32'(INT_id),     32'(m_id));
      chk("model_vec",  INT_Vector,      m_vec);
      chk("model_pend", 32'(pending),    32'(m_pend));
      chk("model_isr",  32'(in_service), 32'(m_isr));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic ack_pulse();
      INT_ack = 1'b1; tick(); INT_ack = 1'b0;
   endtask

   task automatic eoi_pulse();
      INT_eoi = 1'b1; tick(); INT_eoi = 1'b0;
   endtask

   initial begin
      // Reset values
      #12;
      chk("rst_irq", 32'(INT_irq), 32'd0);
      chk("rst_vec", INT_Vector, VB);
      chk("rst_id",  32'(INT_id), 32'd0);
      chk("rst_pend", 32'(pending), 32'd0);
      chk("rst_isr", 32'(in_service), 32'd0);
      Rst = 1'b1;
      tick();

      // Single source 2
      EX_irq = 4'b0100; tick(); tick(); EX_irq = '0;
      chk("s2_early_pend", 32'(pending), 32'd0);
      tick();
      chk("s2_pend", 32'(pending), 32'h4);
      chk("s2_irq_late", 32'(INT_irq), 32'd0);
      tick();
      chk("s2_irq", 32'(INT_irq), 32'd1);
      chk("s2_id", 32'(INT_id), 32'd2);
      chk("s2_vec", INT_Vector, 32'h28);
      ack_pulse();
      chk("s2_ack_pend", 32'(pending), 32'd0);
      chk("s2_ack_isr", 32'(in_service), 32'h4);
      chk("s2_ack_irq", 32'(INT_irq), 32'd0);
      eoi_pulse();
      chk("s2_eoi_isr", 32'(in_service), 32'd0);
      chk("s2_eoi_pend", 32'(pending), 32'd0);

      // Priority: sources 3 and 1 together
      EX_irq = 4'b1010; tick(); tick(); EX_irq = '0; tick(); tick();
      chk("pri_id1", 32'(INT_id), 32'd1);
      chk("pri_vec1", INT_Vector, 32'h24);
      ack_pulse(); eoi_pulse(); tick();
      chk("pri_irq3", 32'(INT_irq), 32'd1);
      chk("pri_id3", 32'(INT_id), 32'd3);
      chk("pri_vec3", INT_Vector, 32'h2C);
      ack_pulse(); eoi_pulse();

      // Mask holds source 0 off until cleared
      mask_we = 1'b1; mask_wdata = 4'b0001; tick(); mask_we = 1'b0;
      EX_irq = 4'b0001; tick(); tick(); EX_irq = '0;
      repeat (3) tick();
      chk("mask_irq", 32'(INT_irq), 32'd0);
      chk("mask_pend", 32'(pending), 32'h1);
      mask_we = 1'b1; mask_wdata = '0; tick(); mask_we = 1'b0;
      chk("unmask_irq_0", 32'(INT_irq), 32'd0);
      tick();
      chk("unmask_irq", 32'(INT_irq), 32'd1);
      chk("unmask_vec", INT_Vector, 32'h20);
      ack_pulse(); eoi_pulse();

      // I_bit holds source 0 off
      I_bit = 1'b1; EX_irq = 4'b0001; tick(); tick(); EX_irq = '0;
      repeat (4) tick();
      chk("ibit_irq", 32'(INT_irq), 32'd0);
      chk("ibit_pend", 32'(pending), 32'h1);
      I_bit = 1'b0; tick();
      chk("ibit_rel_irq", 32'(INT_irq), 32'd1);
      chk("ibit_rel_id", 32'(INT_id), 32'd0);
      ack_pulse(); eoi_pulse();

      // Request stays stable in REQ; doubles as the nesting scenario
      EX_irq = 4'b0100; tick(); tick(); EX_irq = '0; tick(); tick();
      EX_irq = 4'b0001; tick(); tick(); EX_irq = '0; tick(); tick();
      chk("stab_id", 32'(INT_id), 32'd2);
      chk("stab_pend", 32'(pending), 32'h5);
      mask_we = 1'b1; mask_wdata = 4'b1111; I_bit = 1'b1; tick(); mask_we = 1'b0;
      chk("stab_irq_masked", 32'(INT_irq), 32'd1);
      chk("stab_id_masked", 32'(INT_id), 32'd2);
      mask_we = 1'b1; mask_wdata = '0; I_bit = 1'b0; tick(); mask_we = 1'b0;
      ack_pulse();
      chk("stab_ack_isr", 32'(in_service), 32'h4);
      chk("stab_ack_pend", 32'(pending), 32'h1);
`ifndef IRQ_NEST_EN
      eoi_pulse(); tick();
      chk("stab_next_id", 32'(INT_id), 32'd0);
      chk("stab_next_irq", 32'(INT_irq), 32'd1);
      ack_pulse(); eoi_pulse();
`else
      tick();
      chk("nest_irq", 32'(INT_irq), 32'd1);
      chk("nest_id", 32'(INT_id), 32'd0);
      ack_pulse();
      chk("nest_isr2", 32'(in_service), 32'h5);
      eoi_pulse();
      chk("nest_eoi1", 32'(in_service), 32'h4);
      chk("nest_eoi1_irq", 32'(INT_irq), 32'd0);
      eoi_pulse();
      chk("nest_eoi2", 32'(in_service), 32'd0);
`endif

      // Edge on source 1 lands in the same cycle as its ack
      EX_irq = 4'b0010; tick(); tick(); EX_irq = '0; tick(); tick();
      chk("col_id", 32'(INT_id), 32'd1);
      EX_irq = 4'b0010; tick(); tick();
      ack_pulse();
      chk("col_pend", 32'(pending), 32'h2);
      chk("col_isr", 32'(in_service), 32'h2);

      // Asynchronous reset in SERVICE
      #2; Rst = 1'b0; #1;
      chk("arst_irq", 32'(INT_irq), 32'd0);
      chk("arst_vec", INT_Vector, VB);
      chk("arst_pend", 32'(pending), 32'd0);
      chk("arst_isr", 32'(in_service), 32'd0);
      chk("arst_id", 32'(INT_id), 32'd0);
      EX_irq = '0;
      tick(); tick();
      Rst = 1'b1;
      tick();

      // Randomized traffic including stray strobes
      repeat (3000) begin
         for (int i = 0; i < int'(N); i++)
            if ($urandom % 6 == 0) EX_irq[i] = ~EX_irq[i];
         if ($urandom % 20 == 0) I_bit = ~I_bit;
         mask_we    = ($urandom % 25 == 0);
         mask_wdata = N'($urandom);
         INT_ack    = m_irq ? ($urandom % 3 == 0) : ($urandom % 40 == 0);
         INT_eoi    = (!m_irq && m_isr != '0) ? ($urandom % 4 == 0) : ($urandom % 40 == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Vectored, prioritised interrupt controller between N external request lines and the CPU's single IRQ input.
- Synchronises and edge-detects EX_irq sources, latches them as pending and applies a mask.
- Arbitrates by fixed priority and drives INT_irq / INT_Vector to the CPU.
- Uses an ack/EOI handshake with the CPU so that each interrupt is serviced once.

Parameters:
- N_SRC, 4, number of external interrupt sources (1..8).
- VEC_BASE, 32'h00000020, handler address of source 0.
- VEC_STRIDE, 4, byte spacing between consecutive source vectors.

Ports:
- clk  in  1  system clock, rising edge.
- Rst  in  1  reset; asynchronous, active-low.
- EX_irq  in  N_SRC  raw asynchronous interrupt requests.
- I_bit  in  1  CPSR I flag; 1 blocks new requests.
- INT_ack  in  1  one-cycle pulse; CPU has entered IRQ mode.
- INT_eoi  in  1  one-cycle pulse; handler has finished.
- mask_we  in  1  mask register write strobe.
- mask_wdata  in  N_SRC  new mask value; 1 = masked.
- INT_irq  out  1  registered interrupt request to the CPU.
- INT_Vector  out  32  handler address of the granted source.
- INT_id  out  3  index of the granted source.
- pending  out  N_SRC  pending register.
- in_service  out  N_SRC  in-service register.

Behaviour:
- Reset (Rst=0, asynchronous): all outputs and internal registers go to 0, including mask and synchroniser flops. INT_Vector resets to VEC_BASE. FSM goes to IDLE. Reset mid-handshake discards all state.
- Input path:
  - 2-flop synchroniser, then a third flop for edge detect.
  - A rising edge on source i sets pending[i].
  - EX_irq high at edge k sets pending[i] at edge k+2.
  - A level held high sets pending only once.
- Eligibility and priority:
  - eligible = pending & ~mask.
  - Lowest index wins.
- FSM IDLE:
  - If eligible != 0 and I_bit == 0: latch INT_id = winner and INT_Vector = VEC_BASE + INT_id*VEC_STRIDE (32-bit, no overflow check), set INT_irq = 1, go to REQ.
  - INT_irq is therefore high at edge k+3 after a raw edge at k.
- FSM REQ:
  - INT_irq, INT_id and INT_Vector are held stable. Later mask writes, I_bit changes or higher-priority arrivals do not withdraw or change the request.
  - On INT_ack: clear pending[INT_id], set in_service[INT_id], INT_irq = 0, go to SERVICE.
- FSM SERVICE:
  - No new request is issued.
  - On INT_eoi: clear in_service[INT_id], go to IDLE. Re-arbitration happens at the earliest one cycle later.
- Out-of-state strobes: INT_ack outside REQ and INT_eoi outside SERVICE are ignored.
- Simultaneous events:
  - A new edge on source i in the same cycle its pending bit is cleared by ack: set wins, so pending[i] stays 1.
  - mask_we takes effect on the next arbitration.
- Pending bits accumulate while blocked by mask or I_bit and are never lost.

Optional Feature:
- Macro IRQ_NEST_EN.
- When defined:
  - In SERVICE, an eligible source with index lower than every set in_service bit, with I_bit == 0, re-enters REQ with the new INT_id/vector.
  - Ack sets its in_service bit, so several in_service bits may be set.
  - INT_eoi clears the lowest-index (highest-priority) set in_service bit. The FSM returns to IDLE only when in_service == 0; otherwise it stays in SERVICE.
  - Nesting depth is bounded by N_SRC.
- When undefined: strictly non-nesting as described in Behaviour; in_service is one-hot or zero.

Decomposition:
- Shared package irq_pkg: FSM state enum (IDLE, REQ, SERVICE), default VEC_BASE/VEC_STRIDE constants, maximum N_SRC.
- One natural sub-module, irq_sync_edge: per-source 2-flop synchroniser plus rising-edge detect, instantiated N_SRC times.

Test Plan:
- Single source: reset, mask=0, I_bit=0, pulse EX_irq[2] for 2 clocks -> pending[2]=1 two edges later, INT_irq=1 next edge, INT_Vector=32'h28, INT_id=2. Ack clears pending[2] and sets in_service[2]. EOI returns to IDLE with all registers 0.
- Priority: edges on sources 3 and 1 in the same cycle -> INT_id=1, vector 32'h24. After ack+EOI, INT_id=3, vector 32'h2C.
- Masking and I_bit: mask=4'b0001, edge on source 0 -> no INT_irq, pending[0]=1. Unmask -> INT_irq after one cycle. Repeat with I_bit=1 -> held off until I_bit=0.
- Stability in REQ: request source 2, then edge on source 0 before ack -> INT_id stays 2 until ack. After EOI, source 0 is served.
- Collision and reset: EX_irq[1] edge detected in the ack cycle for source 1 -> pending[1] remains 1. Assert Rst mid-SERVICE -> all outputs 0 and INT_Vector=VEC_BASE immediately (asynchronous).
- IRQ_NEST_EN: serving source 2, edge on source 0 -> second REQ with INT_id=0 and in_service=4'b0101. The first EOI clears bit 0. The second EOI clears bit 2 and returns to IDLE.
